bist_ctrl: RTL and testbench
============================

Name: bist_ctrl

Overview:
Sequencer for one built-in self-test session around the 5-bit LFSR pattern generator and the 4-bit SISR signature register. It seeds both registers and enables them for a fixed number of patterns. It then compares the final signature against a golden value and reports done/pass. It sits directly upstream of the TPG/SISR pair and consumes the signature they produce.

Parameters:
N_PAT, 31, number of patterns applied per session (the full 5-bit LFSR period); legal range 1..2^CNT_W-1
CNT_W, 5, width of the internal pattern counter
SIG_W, 4, signature width; must match the SISR
FCNT_W, 4, width of the saturating fail-session counter

Ports:
clk  input  1  rising-edge clock
rst_b  input  1  asynchronous active-low reset
start  input  1  request a session; sampled only in IDLE or DONE
abort  input  1  abandon the current session; return to IDLE
golden  input  SIG_W  expected signature; sampled in CMP
sig  input  SIG_W  current SISR signature
tpg_ld  output  1  one-cycle seed load for the LFSR
sisr_clr  output  1  one-cycle synchronous clear for the SISR
tpg_en  output  1  LFSR advance enable
sisr_en  output  1  SISR compress enable
busy  output  1  high in INIT, RUN, CMP
done  output  1  high in DONE
pass  output  1  result of the last completed session; valid while done=1
fail_cnt  output  FCNT_W  count of failed sessions, saturating

Behaviour:
- Reset (async, rst_b=0): state=IDLE, counter=0, pass=0, fail_cnt=0; all outputs low.
- Outputs are Moore outputs, decoded from the registered state. pass and fail_cnt are registers.
- State IDLE: all strobes low. start=1 at edge k -> INIT.
- State INIT: exactly 1 cycle. tpg_ld=1, sisr_clr=1, counter cleared to 0. -> RUN.
- State RUN: tpg_en=sisr_en=1. Counter increments each cycle. When counter==N_PAT-1 -> CMP. RUN therefore lasts exactly N_PAT cycles.
- State CMP: exactly 1 cycle, strobes low. At the exiting edge:
  - pass <= (sig==golden).
  - On mismatch, fail_cnt increments, saturating at all-ones.
  - -> DONE.
- State DONE: done=1 and pass held stable. start=1 -> INIT, starting a new session directly. pass keeps its old value until the next CMP.
- Latency: start sampled at edge k -> done first high after edge k+N_PAT+2.
- start in INIT/RUN/CMP: ignored, no queuing.
- abort=1 in INIT/RUN/CMP: -> IDLE at the next edge. pass and fail_cnt are unchanged; strobes drop immediately after that edge.
- abort in IDLE/DONE: DONE -> IDLE, which clears done; no effect in IDLE.
- abort and start together: abort wins.
- Counter never wraps. Reaching N_PAT-1 always leaves RUN.
- rst_b asserted mid-session: immediate return to reset values, fail_cnt included.
- Unused state encodings -> IDLE.

Optional Feature:
BIST_SIG_CAPTURE_EN
- Defined: adds output sig_cap[SIG_W-1:0], loaded with sig at the CMP edge. sig_cap resets to 0 and holds until the next CMP, so a failing signature can be read after done.
- Undefined: the port and register are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package/header `bist_defs`:
  - state encodings IDLE=0, INIT=1, RUN=2, CMP=3, DONE=4 (3 bits);
  - default SIG_W=4 and LFSR width 5;
  - N_PAT default 31.
- One natural sub-module, bist_pat_cnt: a pattern counter with clear, enable and terminal-count flag (tc when count==N_PAT-1).

Test Plan:
- Reset then start pulse at edge k -> tpg_ld=sisr_clr=1 for cycle k+1; tpg_en high for exactly 31 cycles; done first high after edge k+33; busy low after that.
- golden driven to the bench-modelled signature of 31 LFSR patterns -> pass=1, fail_cnt=0.
- golden = modelled signature ^ 4'h1 -> pass=0, fail_cnt=1; repeat 16 sessions -> fail_cnt saturates at 4'hF.
- abort asserted in RUN at pattern 10 -> IDLE next cycle, done=0, fail_cnt unchanged. A later start runs the full 31 patterns.
- start held high throughout RUN -> no restart; start in DONE -> INIT next cycle, back-to-back session.
- rst_b pulsed low for 20 time units mid-RUN, asynchronous to clk -> all outputs 0 immediately. With BIST_SIG_CAPTURE_EN defined, sig_cap equals sig at CMP after the session and 0 after reset.

Source files
------------

// File: rtl/bist_defs.sv
// ============================================================================
// Module   : bist_defs
// Purpose  : Shared state encodings and default sizes for the BIST sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bist_defs;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } bist_state_e;

  localparam int unsigned C_SIG_W  = 4;
  localparam int unsigned C_LFSR_W = 5;
  localparam int unsigned C_N_PAT  = 31;
  localparam int unsigned C_CNT_W  = 5;
  localparam int unsigned C_FCNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/bist_ctrl_if.sv
// ============================================================================
// Module   : bist_ctrl_if
// Purpose  : Control/status bundle between the BIST sequencer and the TPG/SISR
//            pair. Optional macro: BIST_SIG_CAPTURE_EN adds sig_cap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bist_ctrl_if
  import bist_defs::*;
#(
  parameter int unsigned SIG_W  = C_SIG_W,
  parameter int unsigned FCNT_W = C_FCNT_W
);

  logic              start;
  logic              abort;
  logic [SIG_W-1:0]  golden;
  logic [SIG_W-1:0]  sig;
  logic              tpg_ld;
  logic              sisr_clr;
  logic              tpg_en;
  logic              sisr_en;
  logic              busy;
  logic              done;
  logic              pass;
  logic [FCNT_W-1:0] fail_cnt;
`ifdef BIST_SIG_CAPTURE_EN
  logic [SIG_W-1:0]  sig_cap;
`endif

  modport master (
    input  start, abort, golden, sig,
    output tpg_ld, sisr_clr, tpg_en, sisr_en, busy, done, pass, fail_cnt
`ifdef BIST_SIG_CAPTURE_EN
    , output sig_cap
`endif
  );

  modport slave (
    output start, abort, golden, sig,
    input  tpg_ld, sisr_clr, tpg_en, sisr_en, busy, done, pass, fail_cnt
`ifdef BIST_SIG_CAPTURE_EN
    , input sig_cap
`endif
  );

endinterface

`default_nettype wire

// File: rtl/bist_pat_cnt.sv
// ============================================================================
// Module   : bist_pat_cnt
// Purpose  : Pattern counter with clear, enable and terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_pat_cnt #(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned N_PAT = 31
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_PAT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holding at the terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tc = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/bist_ctrl.sv
// ============================================================================
// Module   : bist_ctrl
// Purpose  : One-session BIST sequencer: seed, run N_PAT patterns, compare the
//            signature. Optional macro: BIST_SIG_CAPTURE_EN (sig_cap register).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_ctrl
  import bist_defs::*;
#(
  parameter int unsigned N_PAT  = C_N_PAT,
  parameter int unsigned CNT_W  = C_CNT_W,
  parameter int unsigned SIG_W  = C_SIG_W,
  parameter int unsigned FCNT_W = C_FCNT_W
) (
  input  logic        clk,
  input  logic        rst_b,
  bist_ctrl_if.master bus
);

  bist_state_e       r_state;
  bist_state_e       w_next;
  logic              w_tpg_ld;
  logic              w_sisr_clr;
  logic              w_run;
  logic              w_busy;
  logic              w_done;
  logic              w_tc;
  logic              w_cmp_commit;
  logic              w_sig_match;
  logic [SIG_W-1:0]  w_sig;
  logic              r_pass;
  logic [FCNT_W-1:0] r_fail_cnt;

  bist_pat_cnt #(
    .CNT_W (CNT_W),
    .N_PAT (N_PAT)
  ) u_pat_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (w_tpg_ld),
    .en    (w_run),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort outranks start everywhere; start is only honoured in IDLE and DONE.
  always_comb begin
    w_next     = r_state;
    w_tpg_ld   = 1'b0;
    w_sisr_clr = 1'b0;
    w_run      = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) w_next = ST_INIT;
      end
      ST_INIT: begin
        w_tpg_ld   = 1'b1;
        w_sisr_clr = 1'b1;
        w_busy     = 1'b1;
        w_next     = bus.abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        w_run  = 1'b1;
        w_busy = 1'b1;
        if (bus.abort)  w_next = ST_IDLE;
        else if (w_tc)  w_next = ST_CMP;
      end
      ST_CMP: begin
        w_busy = 1'b1;
        w_next = bus.abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (bus.abort)      w_next = ST_IDLE;
        else if (bus.start) w_next = ST_INIT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_sig        = bus.sig;
  assign w_sig_match  = (w_sig == bus.golden);
  assign w_cmp_commit = (r_state == ST_CMP) && !bus.abort;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pass     <= 1'b0;
      r_fail_cnt <= '0;
    end else if (w_cmp_commit) begin
      r_pass <= w_sig_match;
      if (!w_sig_match && (r_fail_cnt != '1)) begin
        r_fail_cnt <= r_fail_cnt + 1'b1;
      end
    end
  end

`ifdef BIST_SIG_CAPTURE_EN
  logic [SIG_W-1:0] r_sig_cap;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sig_cap <= '0;
    end else if (w_cmp_commit) begin
      r_sig_cap <= w_sig;
    end
  end

  assign bus.sig_cap = r_sig_cap;
`endif

  assign bus.tpg_ld   = w_tpg_ld;
  assign bus.sisr_clr = w_sisr_clr;
  assign bus.tpg_en   = w_run;
  assign bus.sisr_en  = w_run;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.pass     = r_pass;
  assign bus.fail_cnt = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bist_ctrl.sv
// ============================================================================
// Module   : tb_bist_ctrl
// Purpose  : Randomised bench for bist_ctrl with an LFSR/SISR environment and a
//            session-level reference model. Honours BIST_SIG_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_ctrl;

  logic       clk   = 1'b0;
  logic       rst_b = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [4:0] env_seed = 5'h01;
  logic [4:0] env_lfsr = 5'h00;
  logic [3:0] env_sisr = 4'h0;

  // Reference model state: what the last completed session should report.
  bit         exp_pass = 1'b0;
  int         exp_fail = 0;
  logic [3:0] exp_cap  = 4'h0;

  bist_ctrl_if #(.SIG_W(4), .FCNT_W(4)) bus ();

  bist_ctrl #(
    .N_PAT (31),
    .CNT_W (5),
    .SIG_W (4),
    .FCNT_W(4)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lfsr_step(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  function automatic logic [3:0] sisr_step(input logic [3:0] s, input logic [3:0] d);
    return {s[2:0], s[3] ^ s[2]} ^ d;
  endfunction

  // Environment: the TPG/SISR pair the sequencer drives.
  always @(posedge clk) begin
    if (bus.tpg_ld)      env_lfsr <= env_seed;
    else if (bus.tpg_en) env_lfsr <= lfsr_step(env_lfsr);
    if (bus.sisr_clr)     env_sisr <= 4'h0;
    else if (bus.sisr_en) env_sisr <= sisr_step(env_sisr, env_lfsr[3:0]);
  end
  assign bus.sig = env_sisr;

  // Signature of 31 patterns: list the pattern sequence, then fold it.
  function automatic logic [3:0] ref_signature(input logic [4:0] seed);
    logic [4:0] pats [31];
    logic [3:0] s;
    pats[0] = seed;
    for (int i = 1; i < 31; i++) pats[i] = lfsr_step(pats[i-1]);
    s = 4'h0;
    for (int i = 0; i < 31; i++) s = sisr_step(s, pats[i][3:0]);
    return s;
  endfunction

  function automatic void model_session(input logic [3:0] sigv, input logic [3:0] gold);
    exp_pass = (sigv == gold);
    if (!exp_pass && exp_fail < 15) exp_fail++;
    exp_cap = sigv;
  endfunction

  // Full session from the current negedge; returns at the negedge where done rises.
  task automatic run_session(input logic [4:0] seed, input logic [3:0] corrupt, input bit hold_start);
    logic [3:0] ref_sig;
    int en_cnt, ld_cnt, done_at;
    ref_sig = ref_signature(seed);
    env_seed = seed;
    bus.golden = ref_sig ^ corrupt;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.tpg_ld, bus.sisr_clr, bus.tpg_en, bus.sisr_en, bus.busy, bus.done} !== 6'b110010)
      $display("FAIL init_strobes: got %b expected %b",
               {bus.tpg_ld, bus.sisr_clr, bus.tpg_en, bus.sisr_en, bus.busy, bus.done}, 6'b110010);
    bus.start = hold_start;
    en_cnt = 0; ld_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      @(negedge clk);
      if (bus.tpg_en) en_cnt++;
      if (bus.tpg_ld) ld_cnt++;
      if (bus.done)   done_at = i;
    end
    bus.start = 1'b0;
    model_session(ref_sig, ref_sig ^ corrupt);
    checks++;
    if (done_at != 33) begin
      errors++; $display("FAIL done_latency: got %0d expected 33 (0 = timeout)", done_at);
    end
    checks++;
    if (en_cnt != 31 || ld_cnt != 0) begin
      errors++; $display("FAIL run_length: got en=%0d ld=%0d expected en=31 ld=0", en_cnt, ld_cnt);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_done: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.pass !== exp_pass) begin
      errors++; $display("FAIL pass: got %b expected %b", bus.pass, exp_pass);
    end
    checks++;
    if (bus.fail_cnt !== 4'(exp_fail)) begin
      errors++; $display("FAIL fail_cnt: got %0h expected %0h", bus.fail_cnt, 4'(exp_fail));
    end
`ifdef BIST_SIG_CAPTURE_EN
    checks++;
    if (bus.sig_cap !== exp_cap) begin
      errors++; $display("FAIL sig_cap: got %h expected %h", bus.sig_cap, exp_cap);
    end
`endif
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.abort = 1'b0; bus.golden = 4'h0;
    #12;
    checks++;
    if ({bus.tpg_ld, bus.sisr_clr, bus.tpg_en, bus.sisr_en, bus.busy, bus.done, bus.pass, bus.fail_cnt} !== 11'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
        {bus.tpg_ld, bus.sisr_clr, bus.tpg_en, bus.sisr_en, bus.busy, bus.done, bus.pass, bus.fail_cnt});
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_pass();
    run_session(5'h01, 4'h0, 1'b0);
    run_session(5'($urandom_range(1, 31)), 4'h0, 1'b0);
  endtask

  task automatic test_fail_saturation();
    for (int s = 0; s < 16; s++) run_session(5'($urandom_range(1, 31)), 4'h1, 1'b0);
    run_session(5'($urandom_range(1, 31)), 4'h0, 1'b0);
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1;
    env_seed = 5'($urandom_range(1, 31));
    @(negedge clk);
    bus.start = 1'b0;
    repeat ($urandom_range(3, 25)) @(negedge clk);
    #3 rst_b = 1'b0;
    #1;
    exp_pass = 1'b0; exp_fail = 0; exp_cap = 4'h0;
    checks++;
    if ({bus.tpg_ld, bus.sisr_clr, bus.tpg_en, bus.sisr_en, bus.busy, bus.done, bus.pass, bus.fail_cnt} !== 11'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0",
        {bus.tpg_ld, bus.sisr_clr, bus.tpg_en, bus.sisr_en, bus.busy, bus.done, bus.pass, bus.fail_cnt});
    end
`ifdef BIST_SIG_CAPTURE_EN
    checks++;
    if (bus.sig_cap !== 4'h0) begin
      errors++; $display("FAIL sig_cap_reset: got %h expected 0", bus.sig_cap);
    end
`endif
    #19 rst_b = 1'b1;
    @(negedge clk);
  endtask

  // Abort at several positions: INIT, pattern 10, random RUN point, CMP.
  task automatic test_abort();
    int points [4];
    logic [3:0] ref_sig;
    points[0] = 0; points[1] = 11; points[2] = $urandom_range(1, 31); points[3] = 32;
    for (int p = 0; p < 4; p++) begin
      env_seed = 5'($urandom_range(1, 31));
      ref_sig = ref_signature(env_seed);
      bus.golden = ref_sig ^ 4'h3;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (points[p]) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if ({bus.tpg_en, bus.sisr_en, bus.busy, bus.done} !== 4'b0000) begin
        errors++; $display("FAIL abort_idle_%0d: got %b expected 0000", points[p],
                           {bus.tpg_en, bus.sisr_en, bus.busy, bus.done});
      end
      checks++;
      if (bus.fail_cnt !== 4'(exp_fail) || bus.pass !== exp_pass) begin
        errors++; $display("FAIL abort_keep_%0d: got pass=%b cnt=%0h expected pass=%b cnt=%0h",
                           points[p], bus.pass, bus.fail_cnt, exp_pass, 4'(exp_fail));
      end
`ifdef BIST_SIG_CAPTURE_EN
      checks++;
      if (bus.sig_cap !== exp_cap) begin
        errors++; $display("FAIL abort_sig_cap: got %h expected %h", bus.sig_cap, exp_cap);
      end
`endif
    end
    // start together with abort in IDLE must stay idle
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_beats_start: got busy=%b expected 0", bus.busy);
    end
    run_session(5'($urandom_range(1, 31)), 4'h0, 1'b0);
    // abort in DONE drops done
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.pass !== exp_pass) begin
      errors++; $display("FAIL abort_in_done: got done=%b pass=%b expected done=0 pass=%b",
                         bus.done, bus.pass, exp_pass);
    end
  endtask

  task automatic test_back_to_back();
    run_session(5'($urandom_range(1, 31)), 4'h0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.pass !== exp_pass) begin
      errors++; $display("FAIL done_hold: got done=%b pass=%b expected done=1 pass=%b",
                         bus.done, bus.pass, exp_pass);
    end
    for (int s = 0; s < 6; s++) begin
      run_session(5'($urandom_range(1, 31)),
                  ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                  $urandom_range(0, 1) != 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.golden = 4'h0;
    test_reset();
    test_pass();
    test_fail_saturation();
    test_async_reset();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

●
